sfp_link_ctrl: RTL and testbench

SFP_LINK_CTRL -- requirements
Module: sfp_link_ctrl

---
 rtl/sfp_link_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_sfp_link_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/sfp_link_ctrl.sv
// SFP link controller: debounced detect/los, OFF/SETTLE/ACTIVE/FAULT sequencing, tone/PRBS7/passthrough tx.
// Define SFP_LINK_PRBS_EN to include the PRBS7 generator; otherwise i_mode=1 falls back to the tone.
module sfp_link_ctrl #(
    parameter int DIV_W      = 27,
    parameter int DEB_CYCLES = 1000,
    parameter int EN_DELAY   = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             detect,
    input  logic             los,
    output logic             shutdown,
    output logic             tx,
    input  logic             i_enable,
    input  logic [1:0]       i_mode,
    input  logic [DIV_W-1:0] i_half_period,
    input  logic             i_data,
    output logic             o_present,
    output logic             o_los,
    output logic [2:0]       o_state,
    output logic             o_fault
);

    localparam logic [2:0] S_OFF    = 3'd0;
    localparam logic [2:0] S_SETTLE = 3'd1;
    localparam logic [2:0] S_ACTIVE = 3'd2;
    localparam logic [2:0] S_FAULT  = 3'd3;

    localparam logic [15:0] DEB_LAST = 16'(DEB_CYCLES - 1);
    localparam logic [23:0] DLY_LAST = 24'(EN_DELAY - 1);

    logic        det_s1, det_s2, los_s1, los_s2;
    logic        det_deb, los_deb;
    logic [15:0] det_cnt, los_cnt;

    // Synchronisers and debouncers reset to the safe "no module, no signal" view.
    always_ff @(posedge clk) begin
        if (rst) begin
            det_s1  <= 1'b1;
            det_s2  <= 1'b1;
            los_s1  <= 1'b1;
            los_s2  <= 1'b1;
            det_deb <= 1'b1;
            los_deb <= 1'b1;
            det_cnt <= '0;
            los_cnt <= '0;
        end else begin
            det_s1 <= detect;
            det_s2 <= det_s1;
            los_s1 <= los;
            los_s2 <= los_s1;
            if (det_s2 == det_deb) begin
                det_cnt <= '0;
            end else if (det_cnt == DEB_LAST) begin
                det_deb <= det_s2;
                det_cnt <= '0;
            end else begin
                det_cnt <= det_cnt + 16'd1;
            end
            if (los_s2 == los_deb) begin
                los_cnt <= '0;
            end else if (los_cnt == DEB_LAST) begin
                los_deb <= los_s2;
                los_cnt <= '0;
            end else begin
                los_cnt <= los_cnt + 16'd1;
            end
        end
    end

    assign o_present = ~det_deb;
    assign o_los     = los_deb;

    logic [2:0]  state, next_state;
    logic [23:0] dly_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_OFF;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = S_OFF;
        if (i_enable && o_present) begin
            case (state)
                S_OFF:    next_state = S_SETTLE;
                S_SETTLE: next_state = (dly_cnt == DLY_LAST) ? S_ACTIVE : S_SETTLE;
                S_ACTIVE: next_state = o_los ? S_FAULT : S_ACTIVE;
                S_FAULT:  next_state = S_FAULT;
                default:  next_state = S_OFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || state != S_SETTLE) begin
            dly_cnt <= '0;
        end else begin
            dly_cnt <= dly_cnt + 24'd1;
        end
    end

    logic [DIV_W-1:0] tone_cnt, tone_cnt_nxt;
    logic             tone_lvl, tone_lvl_nxt;

    // >= rather than == so a half-period shrinking mid-count toggles at once instead of wrapping.
    always_comb begin
        tone_cnt_nxt = tone_cnt + 1'b1;
        tone_lvl_nxt = tone_lvl;
        if (tone_cnt >= i_half_period) begin
            tone_cnt_nxt = '0;
            tone_lvl_nxt = ~tone_lvl;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || state != S_ACTIVE) begin
            tone_cnt <= '0;
            tone_lvl <= 1'b0;
        end else begin
            tone_cnt <= tone_cnt_nxt;
            tone_lvl <= tone_lvl_nxt;
        end
    end

`ifdef SFP_LINK_PRBS_EN
    logic [6:0] lfsr, lfsr_nxt;

    assign lfsr_nxt = {lfsr[5:0], lfsr[6] ^ lfsr[5]};

    always_ff @(posedge clk) begin
        if (rst || state != S_ACTIVE) begin
            lfsr <= 7'h7F;
        end else begin
            lfsr <= lfsr_nxt;
        end
    end
`endif

    logic src_bit;

    always_comb begin
        src_bit = 1'b0;
        case (i_mode)
            2'd0: src_bit = tone_lvl_nxt;
`ifdef SFP_LINK_PRBS_EN
            2'd1: src_bit = lfsr_nxt[6];
`else
            2'd1: src_bit = tone_lvl_nxt;
`endif
            2'd2: src_bit = i_data;
            default: src_bit = 1'b0;
        endcase
    end

    // Outputs are decoded from next_state so the registered pins change on the same edge as the state.
    logic shutdown_nxt, tx_nxt;

    always_comb begin
        shutdown_nxt = 1'b1;
        tx_nxt       = 1'b0;
        if (next_state == S_SETTLE || next_state == S_ACTIVE) begin
            shutdown_nxt = 1'b0;
        end
        if (state == S_ACTIVE && next_state == S_ACTIVE) begin
            tx_nxt = src_bit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shutdown <= 1'b1;
            tx       <= 1'b0;
        end else begin
            shutdown <= shutdown_nxt;
            tx       <= tx_nxt;
        end
    end

    assign o_state = state;
    assign o_fault = (state == S_FAULT);

endmodule

// File: tb/tb_sfp_link_ctrl.sv
// Directed bench for sfp_link_ctrl with small DEB_CYCLES/EN_DELAY; expected values queued then checked.
`timescale 1ns/1ps
module tb_sfp_link_ctrl;

    localparam int DIV_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             detect, los, i_enable, i_data;
    logic [1:0]       i_mode;
    logic [DIV_W-1:0] i_half_period;
    logic             shutdown, tx, o_present, o_los, o_fault;
    logic [2:0]       o_state;

    int compared   = 0;
    int mismatched = 0;
    logic [7:0] exp_q[$];

    sfp_link_ctrl #(.DIV_W(DIV_W), .DEB_CYCLES(4), .EN_DELAY(10)) dut (
        .clk(clk), .rst(rst), .detect(detect), .los(los),
        .shutdown(shutdown), .tx(tx), .i_enable(i_enable), .i_mode(i_mode),
        .i_half_period(i_half_period), .i_data(i_data),
        .o_present(o_present), .o_los(o_los), .o_state(o_state), .o_fault(o_fault)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [7:0] obs);
        logic [7:0] exp_v;
        compared++;
        if (exp_q.size() == 0) begin
            mismatched++;
            $error("FAIL %s: observed %0h, no expected value queued", tag, obs);
        end else begin
            exp_v = exp_q.pop_front();
            assert (obs === exp_v) else begin
                mismatched++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
            end
        end
    endtask

    initial begin
        logic [6:0] m;
        logic       d;
        rst = 1'b1; detect = 1'b1; los = 1'b1; i_enable = 1'b0;
        i_mode = 2'd0; i_half_period = 8'd49; i_data = 1'b0;
        step(3);
        push(0); check("rst_state", o_state);
        push(1); check("rst_shutdown", shutdown);
        push(0); check("rst_tx", tx);
        push(0); check("rst_fault", o_fault);
        push(0); check("rst_present", o_present);
        push(1); check("rst_los", o_los);

        // Short detect glitch must be rejected; a long one accepted after 2+4 cycles.
        rst = 1'b0; detect = 1'b0;
        step(3);
        detect = 1'b1;
        step(6);
        push(0); check("glitch_present", o_present);
        detect = 1'b0; los = 1'b0;
        step(5);
        push(0); check("deb_early_present", o_present);
        step(1);
        push(1); check("deb_present", o_present);
        push(0); check("deb_los_clear", o_los);

        i_enable = 1'b1;
        step(1);
        push(1); check("settle_state", o_state);
        push(0); check("settle_shutdown", shutdown);
        step(9);
        push(1); check("settle_hold", o_state);
        step(1);
        push(2); check("active_state", o_state);

        for (int i = 1; i <= 200; i++) begin
            push(8'((i / 50) % 2));
            step(1);
            check("tone_hp49", tx);
        end

        i_mode = 2'd2;
        for (int i = 0; i < 10; i++) begin
            d = 1'($urandom_range(0, 1));
            i_data = d;
            push(8'(d));
            step(1);
            check("passthrough", tx);
        end

        i_mode = 2'd3; i_data = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(0);
            step(1);
            check("const_zero", tx);
        end

        los = 1'b1;
        step(6);
        push(1); check("los_deb", o_los);
        push(2); check("los_still_active", o_state);
        step(1);
        push(3); check("fault_state", o_state);
        push(1); check("fault_flag", o_fault);
        push(1); check("fault_shutdown", shutdown);
        push(0); check("fault_tx", tx);

        i_enable = 1'b0; los = 1'b0;
        step(1);
        push(0); check("fault_to_off", o_state);
        push(0); check("off_fault_clear", o_fault);
        i_enable = 1'b1; i_mode = 2'd1; i_half_period = 8'd2;
        step(1);
        push(1); check("reenable_settle", o_state);
        step(9);
        push(1); check("reenable_hold", o_state);
        step(1);
        push(2); check("reenable_active", o_state);

        m = 7'h7F;
        for (int i = 1; i <= 14; i++) begin
`ifdef SFP_LINK_PRBS_EN
            m = {m[5:0], m[6] ^ m[5]};
            push(8'(m[6]));
`else
            push(8'((i / 3) % 2));
`endif
            step(1);
            check("mode1_tx", tx);
        end

        detect = 1'b1;
        step(6);
        push(0); check("pull_present", o_present);
        push(2); check("pull_still_active", o_state);
        step(1);
        push(0); check("pull_off", o_state);
        push(1); check("pull_shutdown", shutdown);
        push(0); check("pull_tx", tx);

        detect = 1'b0;
        step(7);
        push(1); check("refit_settle", o_state);
        rst = 1'b1;
        step(1);
        push(0); check("midrst_state", o_state);
        push(1); check("midrst_shutdown", shutdown);
        push(0); check("midrst_present", o_present);
        push(1); check("midrst_los", o_los);
        rst = 1'b0;
        step(6);
        push(0); check("postrst_off", o_state);
        step(1);
        push(1); check("postrst_settle", o_state);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
